// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, a decode stage that
// requests pixels one cycle early, and an output stage aligning sync/de/data.
module video_timing_gen #(
  parameter int unsigned DW       = 24,
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic          o_req,
  output logic [DW-1:0] o_data,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [11:0]   hcount,
  output logic [11:0]   vcount,
  output logic          o_fs
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_ACTIVE + H_FP;
  localparam int unsigned H_SE    = H_SS + H_SYNC;
  localparam int unsigned V_SS    = V_ACTIVE + V_FP;
  localparam int unsigned V_SE    = V_SS + V_SYNC;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_last_c;
  logic          v_last_c;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;

  logic          hs_d;
  logic          vs_d;
  logic [CW-1:0] x_d;
  logic [CW-1:0] y_d;

  // Counter position decode
  always_comb begin
    h_last_c = (h_cnt == CW'(H_TOTAL - 1));
    v_last_c = (v_cnt == CW'(V_TOTAL - 1));
    active_c = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    hs_c     = (h_cnt >= CW'(H_SS)) && (h_cnt < CW'(H_SE));
    vs_c     = (v_cnt >= CW'(V_SS)) && (v_cnt < CW'(V_SE));
  end

  // Raster counters; line and frame wrap resolve together to (0,0)
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!i_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Stage 1: registered decode, gated by enable so a disabled generator is idle
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      o_req <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      x_d   <= '0;
      y_d   <= '0;
    end else begin
      o_req <= i_en & active_c;
      hs_d  <= i_en & hs_c;
      vs_d  <= i_en & vs_c;
      x_d   <= i_en ? h_cnt : '0;
      y_d   <= i_en ? v_cnt : '0;
    end
  end

  // Stage 2: outputs; upstream pixel arrives one cycle after its request
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      o_de    <= 1'b0;
      o_hsync <= ~HS_POL;
      o_vsync <= ~VS_POL;
      hcount  <= '0;
      vcount  <= '0;
      o_fs    <= 1'b0;
      o_data  <= '0;
    end else begin
      o_de    <= o_req;
      o_hsync <= hs_d ? HS_POL : ~HS_POL;
      o_vsync <= vs_d ? VS_POL : ~VS_POL;
      hcount  <= x_d;
      vcount  <= y_d;
      o_fs    <= o_req && (x_d == '0) && (y_d == '0);
      o_data  <= o_req ? i_data : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 17x9 raster
// (8+2+3+4 pixels, 4+1+2+2 lines, hsync active-low, vsync active-high).
module tb_video_timing_gen;

  localparam int unsigned DW = 8;

  logic          pixelclk = 1'b0;
  logic          reset    = 1'b1;
  logic          i_en     = 1'b0;
  logic [DW-1:0] i_data   = '0;
  logic          o_req;
  logic [DW-1:0] o_data;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic [11:0]   hcount;
  logic [11:0]   vcount;
  logic          o_fs;

  video_timing_gen #(
    .DW(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .i_en(i_en), .i_data(i_data),
    .o_req(o_req), .o_data(o_data), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .hcount(hcount), .vcount(vcount), .o_fs(o_fs)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct {
    int         due;
    logic       en;
    logic       de;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] data;
    int         x;
    int         y;
  } exp_t;

  typedef struct {
    int   due;
    logic req;
  } req_t;

  exp_t sq[$];
  req_t rq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         mx   = 0;
  int         my   = 0;
  logic [7:0] midx = 8'd1;
  logic [7:0] didx = 8'd1;

  always @(posedge pixelclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"},   32'(o_req),   32'd0);
    chk({tag, "_de"},    32'(o_de),    32'd0);
    chk({tag, "_fs"},    32'(o_fs),    32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_hcnt"},  32'(hcount),  32'd0);
    chk({tag, "_vcnt"},  32'(vcount),  32'd0);
    chk({tag, "_hsync"}, 32'(o_hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(o_vsync), 32'd0);
  endtask

  // One pixel period of stimulus plus the expected outputs it must produce
  task automatic drive(input logic en, input logic rel);
    exp_t e;
    req_t r;
    logic act;
    @(negedge pixelclk);
    if (rel) reset = 1'b0;
    i_en = en;
    e.due = cyc + 2;
    e.en  = en;
    e.x   = 0;
    e.y   = 0;
    if (en) begin
      act    = (mx < 8) && (my < 4);
      e.de   = act;
      e.fs   = act && (mx == 0) && (my == 0);
      e.hs   = (mx >= 10 && mx < 13) ? 1'b0 : 1'b1;
      e.vs   = (my >= 5 && my < 7) ? 1'b1 : 1'b0;
      e.data = act ? midx : 8'd0;
      e.x    = mx;
      e.y    = my;
      if (act) midx++;
      mx++;
      if (mx == 17) begin
        mx = 0;
        my++;
        if (my == 9) my = 0;
      end
    end else begin
      act    = 1'b0;
      e.de   = 1'b0;
      e.fs   = 1'b0;
      e.hs   = 1'b1;
      e.vs   = 1'b0;
      e.data = 8'd0;
      mx     = 0;
      my     = 0;
    end
    r.due = cyc + 1;
    r.req = act;
    sq.push_back(e);
    rq.push_back(r);
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1 check_idle("async_rst");
    sq.delete();
    rq.delete();
    mx   = 0;
    my   = 0;
    midx = 8'd1;
    repeat (3) begin
      @(negedge pixelclk);
      #1 check_idle("rst_hold");
    end
  endtask

  // Upstream source: answers each request with the next index
  always @(negedge pixelclk) begin
    if (reset) didx = 8'd1;
    else if (o_req) begin
      i_data = didx;
      didx++;
    end
  end

  exp_t me;
  req_t mr;

  // Scoreboard monitor
  always @(negedge pixelclk) begin
    if (!reset) begin
      while (rq.size() > 0 && rq[0].due < cyc) begin
        mr = rq.pop_front();
        chk("req_missed", 32'(cyc), 32'(mr.due));
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mr = rq.pop_front();
        chk("req", 32'(o_req), 32'(mr.req));
      end
      while (sq.size() > 0 && sq[0].due < cyc) begin
        me = sq.pop_front();
        chk("out_missed", 32'(cyc), 32'(me.due));
      end
      if (sq.size() > 0 && sq[0].due == cyc) begin
        me = sq.pop_front();
        chk("de",    32'(o_de),    32'(me.de));
        chk("fs",    32'(o_fs),    32'(me.fs));
        chk("data",  32'(o_data),  32'(me.data));
        chk("hsync", 32'(o_hsync), 32'(me.hs));
        chk("vsync", 32'(o_vsync), 32'(me.vs));
        if (me.en) begin
          chk("hcount", 32'(hcount), 32'(me.x));
          chk("vcount", 32'(vcount), 32'(me.y));
        end
      end
    end
  end

  int  fr_cnt = 0;
  int  de_cnt = 0;
  int  hs_cnt = 0;
  int  vs_cnt = 0;
  bit  have_fs = 1'b0;
  bit  clean   = 1'b0;

  // Whole-frame totals between consecutive undisturbed frame starts
  always @(negedge pixelclk) begin
    if (reset || !i_en) clean = 1'b0;
    if (o_fs && !reset) begin
      if (have_fs && clean) begin
        chk("frame_period", 32'(fr_cnt), 32'd153);
        chk("de_per_frame", 32'(de_cnt), 32'd32);
        chk("hs_per_frame", 32'(hs_cnt), 32'd27);
        chk("vs_per_frame", 32'(vs_cnt), 32'd34);
      end
      have_fs = 1'b1;
      clean   = 1'b1;
      fr_cnt  = 0;
      de_cnt  = 0;
      hs_cnt  = 0;
      vs_cnt  = 0;
    end
    fr_cnt++;
    if (o_de) de_cnt++;
    if (!o_hsync) hs_cnt++;
    if (o_vsync) vs_cnt++;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge pixelclk);
    check_idle("por");
    i_en = 1'b1;
    @(negedge pixelclk);
    #1 check_idle("rst_dom");

    drive(1'b1, 1'b1);
    repeat (400) drive(1'b1, 1'b0);

    while (!(mx == 5 && my == 2)) drive(1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    repeat (250) drive(1'b1, 1'b0);

    while (!(mx == 4 && my == 1)) drive(1'b1, 1'b0);
    reset_pulse();
    drive(1'b1, 1'b1);
    repeat (320) drive(1'b1, 1'b0);

    repeat (3) drive(1'b0, 1'b0);
    repeat (3) @(negedge pixelclk);
    #1 chk("sb_empty", 32'(sq.size() + rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DW, 24, pixel data width
  H_ACTIVE, 1024, active pixels per line
  H_FP, 24, horizontal front porch in pixels
  H_SYNC, 136, hsync width in pixels
  H_BP, 160, horizontal back porch in pixels
  V_ACTIVE, 768, active lines per frame
  V_FP, 3, vertical front porch in lines
  V_SYNC, 6, vsync width in lines
  V_BP, 29, vertical back porch in lines
  HS_POL, 0, asserted hsync level
  VS_POL, 0, asserted vsync level
REQ-002 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
  pixelclk  in  1  pixel clock, rising edge
  reset  in  1  async active-high reset
  i_en  in  1  timing enable
  i_data  in  DW  pixel from upstream, valid the cycle after o_req
  o_req  out  1  pixel request, one cycle ahead of o_de
  o_data  out  DW  pixel aligned with o_de
  o_hsync  out  1  horizontal sync
  o_vsync  out  1  vertical sync
  o_de  out  1  active-video enable
  hcount  out  12  active x coordinate
  vcount  out  12  active y coordinate
  o_fs  out  1  frame-start pulse

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806). Internal counters h_cnt and v_cnt SHALL be 12-bit.
REQ-005 h_cnt SHALL increment every cycle while i_en=1 and wrap from H_TOTAL-1 to 0. v_cnt SHALL increment when h_cnt wraps and wrap from V_TOTAL-1 to 0.
REQ-006 Region order SHALL be active, front porch, sync, back porch on both axes; active means h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-007 Stage 1 (registered decode of the counters):
  - o_req = active;
  - hs_d = asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC;
  - vs_d = asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC;
  - x_d/y_d = h_cnt/v_cnt.
REQ-008 Stage 2 (registered from stage 1):
  - o_de = o_req delayed one cycle;
  - o_hsync = hs_d ? HS_POL : ~HS_POL;
  - o_vsync = vs_d ? VS_POL : ~VS_POL;
  - hcount = x_d, vcount = y_d;
  - o_fs = o_req & (x_d==0) & (y_d==0).
REQ-009 o_data SHALL register i_data when o_req=1, else 0, so o_data is nonzero only while o_de=1.
REQ-010 Latency from counter value to o_req SHALL be 1 cycle, and to all stage-2 outputs 2 cycles. hsync, vsync, de, hcount, vcount, data and fs SHALL be mutually cycle-aligned.
REQ-011 When i_en=0, h_cnt and v_cnt SHALL be forced to 0, o_req/o_de/o_fs SHALL be 0, syncs inactive, and o_data 0 (after the pipeline drains, 2 cycles).
REQ-012 Re-asserting i_en SHALL restart timing at (0,0). The first o_de SHALL occur 2 cycles later, with o_fs=1.
REQ-013 hcount/vcount SHALL hold the coordinate of the current stage-2 position, including blanking values, and SHALL be meaningful only while o_de=1.
REQ-014 A line-end wrap and a frame-end wrap in the same cycle SHALL take effect together: next (h_cnt,v_cnt)=(0,0).

Reset
REQ-015 While reset=1, asynchronously:
  - counters = 0;
  - o_req, o_de, o_fs, o_data, hcount, vcount = 0;
  - o_hsync = ~HS_POL, o_vsync = ~VS_POL.
REQ-016 Reset SHALL dominate i_en. Reset mid-frame SHALL abort the frame with no glitch pulse on o_fs. After release, behaviour SHALL match REQ-012.

Verification
REQ-017 Release reset with i_en=1 -> o_req=1 after the 1st rising edge; o_de=1, o_fs=1, hcount=0, vcount=0 after the 2nd.
REQ-018 Run one full frame (defaults) -> 1,083,264 cycles between o_fs pulses; 1024 o_de cycles per active line; 768 active lines; o_fs exactly once per frame.
REQ-019 Line timing check -> o_hsync low for exactly 136 cycles, starting 24 cycles after o_de falls; 160 cycles from hsync deassert to the next o_de rise.
REQ-020 Frame timing check -> o_vsync low for lines 771..776 (6 lines); o_de=0 on lines 768..805.
REQ-021 Drive i_data = counter incremented on each o_req -> o_data equals the request index and is aligned with o_de; o_data=0 during blanking.
REQ-022 Deassert i_en at pixel (500,300), then reassert -> outputs idle within 2 cycles; restart at (0,0) with o_fs. Assert reset mid-line -> immediate idle values per REQ-015.
